// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int ARB_ADDR_W_DEF  = 9;
   localparam int ARB_MEM_LAT_DEF = 1;
   localparam int ARB_DATA_W      = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_e;

   typedef enum logic {
      ARB_CPU = 1'b0,
      ARB_DBG = 1'b1
   } arb_id_e;

   // Owner and direction of the transaction currently holding memory.
   typedef struct packed {
      arb_id_e id;
      logic    write;
   } arb_hdr_t;

   function automatic arb_id_e arb_other(input arb_id_e id);
      return (id == ARB_CPU) ? ARB_DBG : ARB_CPU;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the cpu and dbg requesters.
// MEM_ARB_ROUND_ROBIN_EN: contention goes to the port not granted last; otherwise cpu always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    cpu_req_i,
   input  logic    dbg_req_i,
   input  arb_id_e last_i,
   output arb_id_e win_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      win_o = ARB_CPU;
      if (cpu_req_i && dbg_req_i) begin
         win_o = arb_other(last_i);
      end else if (dbg_req_i) begin
         win_o = ARB_DBG;
      end
   end
`else
   logic unused_last;
   assign unused_last = last_i;

   always_comb begin
      win_o = ARB_CPU;
      if (dbg_req_i && !cpu_req_i) begin
         win_o = ARB_DBG;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (cpu/dbg) single-memory arbiter: IDLE -> ACCESS -> [WAIT] -> DONE.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin contention; default build is fixed cpu priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W_DEF,
   parameter int MEM_LAT = ARB_MEM_LAT_DEF
) (
   input  logic              clk,
   input  logic              in_reset_n,
   input  logic              in_cpu_req,
   input  logic              in_cpu_write,
   input  logic [ADDR_W-1:0] in_cpu_addr,
   input  logic [31:0]       in_cpu_wdata,
   input  logic              in_dbg_req,
   input  logic              in_dbg_write,
   input  logic [ADDR_W-1:0] in_dbg_addr,
   input  logic [31:0]       in_dbg_wdata,
   output logic              out_cpu_grant,
   output logic              out_dbg_grant,
   output logic              out_cpu_done,
   output logic              out_dbg_done,
   output logic [31:0]       out_cpu_rdata,
   output logic [31:0]       out_dbg_rdata,
   output logic [ADDR_W-1:0] out_mem_addr,
   output logic [31:0]       out_mem_wdata,
   output logic              out_mem_read,
   output logic              out_mem_write,
   input  logic [31:0]       in_mem_rdata,
   output logic              out_busy
);

   // MEM_LAT is limited to 0..7 so it fits the 3-bit wait counter.
   localparam logic [2:0] LAT3 = 3'(MEM_LAT);

   arb_state_e        state_q, state_d;
   arb_hdr_t          hdr_q, hdr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic [31:0]       dbg_rdata_q, dbg_rdata_d;
   logic              capture;
   logic              any_req;
   arb_id_e           win;
   arb_id_e           last;

   assign any_req = in_cpu_req | in_dbg_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   arb_id_e last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (state_q == ST_IDLE && any_req) begin
         last_d = win;
      end
   end

   // Resets to dbg so the first contention after reset goes to cpu.
   always_ff @(posedge clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         last_q <= ARB_DBG;
      end else begin
         last_q <= last_d;
      end
   end

   assign last = last_q;
`else
   assign last = ARB_DBG;
`endif

   mem_arb_pick u_pick (
      .cpu_req_i (in_cpu_req),
      .dbg_req_i (in_dbg_req),
      .last_i    (last),
      .win_o     (win)
   );

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      capture     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d  = ST_ACCESS;
               hdr_d.id = win;
               if (win == ARB_CPU) begin
                  hdr_d.write = in_cpu_write;
                  addr_d      = in_cpu_addr;
                  wdata_d     = in_cpu_wdata;
               end else begin
                  hdr_d.write = in_dbg_write;
                  addr_d      = in_dbg_addr;
                  wdata_d     = in_dbg_wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (hdr_q.write || LAT3 == 3'd0) begin
               state_d = ST_DONE;
               capture = !hdr_q.write;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = LAT3;
            end
         end
         ST_WAIT: begin
            // Last wait cycle is the one MEM_LAT cycles after ACCESS began.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = ST_DONE;
               capture = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture) begin
         if (hdr_q.id == ARB_CPU) begin
            cpu_rdata_d = in_mem_rdata;
         end else begin
            dbg_rdata_d = in_mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q     <= ST_IDLE;
         hdr_q       <= '{id: ARB_CPU, write: 1'b0};
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign out_busy      = (state_q != ST_IDLE);
   assign out_cpu_grant = out_busy && (hdr_q.id == ARB_CPU);
   assign out_dbg_grant = out_busy && (hdr_q.id == ARB_DBG);
   assign out_cpu_done  = (state_q == ST_DONE) && (hdr_q.id == ARB_CPU);
   assign out_dbg_done  = (state_q == ST_DONE) && (hdr_q.id == ARB_DBG);
   assign out_mem_read  = (state_q == ST_ACCESS) && !hdr_q.write;
   assign out_mem_write = (state_q == ST_ACCESS) && hdr_q.write;
   assign out_mem_addr  = addr_q;
   assign out_mem_wdata = wdata_q;
   assign out_cpu_rdata = cpu_rdata_q;
   assign out_dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at MEM_LAT 0, 1 and 7 share one memory model.
module tb_mem_arbiter;
   localparam int AW = 9;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cpu_req = 0, cpu_wr = 0, dbg_req = 0, dbg_wr = 0;
   logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
   logic [31:0]   cpu_wd = '0, dbg_wd = '0;

   logic [ND-1:0]         g_cpu, g_dbg, d_cpu, d_dbg, mrd, mwr, busy;
   logic [ND-1:0][31:0]   r_cpu, r_dbg, mwd;
   logic [ND-1:0][AW-1:0] maddr;

   logic [31:0]   mem [0:511];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_a = '0;
   logic [31:0]   ld_d = '0;

   int total = 0;
   int bad = 0;

   // Memory writes follow the MEM_LAT=1 instance, which all directed sequences track.
   always @(posedge clk) begin
      if (ld_en) mem[ld_a] <= ld_d;
      else if (mwr[1]) mem[maddr[1]] <= mwd[1];
   end

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 7);
      logic [7:0]         vp = '0;
      logic [7:0][AW-1:0] ap = '0;
      logic [31:0]        rd;

      always @(posedge clk) begin
         vp <= {vp[6:0], mrd[g]};
         ap <= {ap[6:0], maddr[g]};
      end

      // Read data is valid only in the cycle exactly L cycles after the strobe.
      if (L == 0) begin : g_l0
         assign rd = mrd[g] ? mem[maddr[g]] : 32'hBAD0_BAD0;
      end else begin : g_ln
         assign rd = vp[L-1] ? mem[ap[L-1]] : 32'hBAD0_BAD0;
      end

      mem_arbiter #(.ADDR_W(AW), .MEM_LAT(L)) u_dut (
         .clk           (clk),
         .in_reset_n    (rst_n),
         .in_cpu_req    (cpu_req),
         .in_cpu_write  (cpu_wr),
         .in_cpu_addr   (cpu_addr),
         .in_cpu_wdata  (cpu_wd),
         .in_dbg_req    (dbg_req),
         .in_dbg_write  (dbg_wr),
         .in_dbg_addr   (dbg_addr),
         .in_dbg_wdata  (dbg_wd),
         .out_cpu_grant (g_cpu[g]),
         .out_dbg_grant (g_dbg[g]),
         .out_cpu_done  (d_cpu[g]),
         .out_dbg_done  (d_dbg[g]),
         .out_cpu_rdata (r_cpu[g]),
         .out_dbg_rdata (r_dbg[g]),
         .out_mem_addr  (maddr[g]),
         .out_mem_wdata (mwd[g]),
         .out_mem_read  (mrd[g]),
         .out_mem_write (mwr[g]),
         .in_mem_rdata  (rd),
         .out_busy      (busy[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("grant_excl", 32'(g_cpu[1] & g_dbg[1]), 32'd0);
   end

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 32'({g_cpu[1], g_dbg[1], d_cpu[1], d_dbg[1], mrd[1], mwr[1], busy[1]}), 32'd0);
      chk({tag, "_addr"}, 32'(maddr[1]), 32'd0);
      chk({tag, "_wdata"}, mwd[1], 32'd0);
      chk({tag, "_cpu_rdata"}, r_cpu[1], 32'd0);
      chk({tag, "_dbg_rdata"}, r_dbg[1], 32'd0);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_a = a; ld_d = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // One transaction on the MEM_LAT=1 instance; lat is the observed done cycle relative to the sampling edge.
   task automatic run_txn(input logic port, input logic wr, input logic [AW-1:0] a,
                          input logic [31:0] d, input int drop_at,
                          output int lat, output int nst, output logic [AW-1:0] sa,
                          output logic [31:0] sd, output logic sw, output logic gok);
      lat = -1; nst = 0; sa = '0; sd = '0; sw = 1'b0; gok = 1'b1;
      @(negedge clk);
      if (port) begin
         dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_wd = d;
      end else begin
         cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wd = d;
      end
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (mrd[1] || mwr[1]) begin
            nst++; sa = maddr[1]; sd = mwd[1]; sw = mwr[1];
         end
         if (port ? (!g_dbg[1] || g_cpu[1]) : (!g_cpu[1] || g_dbg[1])) gok = 1'b0;
         if (n == drop_at) begin cpu_req = 1'b0; dbg_req = 1'b0; end
         if (port ? d_dbg[1] : d_cpu[1]) begin lat = n; break; end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
   endtask

   typedef struct {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      int            drop_at;
      int            exp_lat;
      logic [31:0]   exp_cpu;
      logic [31:0]   exp_dbg;
   } vec_t;

   initial begin
      vec_t          vt [9];
      int            lat, nst;
      logic [AW-1:0] sa;
      logic [31:0]   sd;
      logic          sw, gok, seen;
      int            llat [ND];
      int            lnst [ND];
      int            order [4];
      int            nord;
      int            exp_order [4];

      vt[0] = '{1'b0, 1'b0, 9'h010, 32'h0,         1, 3, 32'hDEADBEEF, 32'h0};
      vt[1] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678,  1, 2, 32'hDEADBEEF, 32'h0};
      vt[2] = '{1'b0, 1'b0, 9'h1FF, 32'h0,         2, 3, 32'h12345678, 32'h0};
      vt[3] = '{1'b1, 1'b0, 9'h020, 32'h0,         1, 3, 32'h12345678, 32'hCAFEF00D};
      vt[4] = '{1'b0, 1'b1, 9'h000, 32'hA5A5A5A5,  1, 2, 32'h12345678, 32'hCAFEF00D};
      vt[5] = '{1'b1, 1'b0, 9'h000, 32'h0,         2, 3, 32'h12345678, 32'hA5A5A5A5};
      vt[6] = '{1'b0, 1'b0, 9'h000, 32'h0,         2, 3, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vt[7] = '{1'b1, 1'b1, 9'h010, 32'h0F0F0F0F,  1, 2, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vt[8] = '{1'b0, 1'b0, 9'h010, 32'h0,         1, 3, 32'h0F0F0F0F, 32'hA5A5A5A5};

      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      load(9'h010, 32'hDEADBEEF);
      load(9'h020, 32'hCAFEF00D);
      release_reset();

      for (int i = 0; i < 9; i++) begin
         run_txn(vt[i].port, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].drop_at, lat, nst, sa, sd, sw, gok);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_strobes", i), 32'(nst), 32'd1);
         chk($sformatf("v%0d_kind", i), 32'(sw), 32'(vt[i].wr));
         chk($sformatf("v%0d_addr", i), 32'(sa), 32'(vt[i].addr));
         if (vt[i].wr) chk($sformatf("v%0d_wdata", i), sd, vt[i].wd);
         chk($sformatf("v%0d_grant", i), 32'(gok), 32'd1);
         chk($sformatf("v%0d_cpu_rdata", i), r_cpu[1], vt[i].exp_cpu);
         chk($sformatf("v%0d_dbg_rdata", i), r_dbg[1], vt[i].exp_dbg);
         @(posedge clk); #1;
         chk($sformatf("v%0d_idle", i), 32'(busy[1]), 32'd0);
      end

      // Reset during the WAIT cycle of a cpu read.
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 9'h020;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid_busy", 32'(busy[1] & g_cpu[1] & ~mrd[1]), 32'd1);
      rst_n = 1'b0;
      #1 check_zero("rst_mid");
      cpu_req = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (d_cpu[1]) seen = 1'b1;
      end
      chk("rst_mid_nodone", 32'(seen), 32'd0);
      release_reset();
      run_txn(1'b0, 1'b0, 9'h010, 32'h0, 1, lat, nst, sa, sd, sw, gok);
      chk("rst_after_lat", 32'(lat), 32'd3);
      chk("rst_after_rdata", r_cpu[1], 32'h0F0F0F0F);
      chk("rst_after_dbg", r_dbg[1], 32'h0);

      // Same read on all three latencies, starting from reset.
      rst_n = 1'b0;
      release_reset();
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 9'h020;
      for (int g = 0; g < ND; g++) begin llat[g] = -1; lnst[g] = 0; end
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         if (n == 1) cpu_req = 1'b0;
         for (int g = 0; g < ND; g++) begin
            if (mrd[g] || mwr[g]) lnst[g]++;
            if (d_cpu[g] && llat[g] < 0) llat[g] = n;
         end
      end
      chk("lat0_done", 32'(llat[0]), 32'd2);
      chk("lat1_done", 32'(llat[1]), 32'd3);
      chk("lat7_done", 32'(llat[2]), 32'd9);
      for (int g = 0; g < ND; g++) begin
         chk($sformatf("lat_g%0d_strobes", g), 32'(lnst[g]), 32'd1);
         chk($sformatf("lat_g%0d_rdata", g), r_cpu[g], 32'hCAFEF00D);
      end

      // Contention: both requesters held for four transactions.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      rst_n = 1'b0;
      release_reset();
      @(negedge clk);
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 9'h005; cpu_wd = 32'h1111;
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 9'h006; dbg_wd = 32'h2222;
      nord = 0;
      for (int n = 0; n < 40 && nord < 4; n++) begin
         @(posedge clk); #1;
         if (d_cpu[1]) begin order[nord] = 0; nord++; end
         else if (d_dbg[1]) begin order[nord] = 1; nord++; end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      chk("cont_count", 32'(nord), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < nord) chk($sformatf("cont_win%0d", i), 32'(order[i]), 32'(exp_order[i]));
      end
      repeat (4) @(posedge clk);
      #1 chk("cont_idle", 32'(busy[1]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
